mem_master: RTL and testbench
=============================

// Module: mem_master
// PURPOSE
//  Bus initiator for the async-write/combinational-read `memory` block: drives rw/addr/data, samples read data.
//  Accepts single-word READ/WRITE and multi-word FILL/COPY commands over a valid/ready port.
//  Returns read data over a valid/ready response port.
//  Sits between the CPU core and data memory.
// PARAMETERS
//  BITS      8    data and address width
//  MEMADDRS  256  memory depth. Addresses wrap mod 2**BITS. Caller keeps addresses < MEMADDRS.
// PORTS
//  i_clk         in   1     clock, rising edge
//  i_rst_n       in   1     reset, asynchronous, active-low
//  i_cmd_valid   in   1     command offered
//  o_cmd_ready   out  1     command accepted when valid&&ready at a rising edge
//  i_cmd_op      in   2     0 READ, 1 WRITE, 2 FILL, 3 COPY
//  i_cmd_addr    in   BITS  READ/WRITE/FILL address; COPY source
//  i_cmd_aux     in   BITS  WRITE data; FILL value; COPY destination
//  i_cmd_len     in   BITS  FILL/COPY word count; ignored for READ/WRITE
//  o_rsp_valid   out  1     read data available
//  i_rsp_ready   in   1     response consumed
//  o_rsp_data    out  BITS  read data
//  o_done        out  1     one-cycle pulse at command completion
//  o_busy        out  1     high while any command is in progress
//  o_mem_rw      out  1     to memory i_rw (1 = write)
//  o_mem_addr    out  BITS  to memory i_addr
//  o_mem_wdata   out  BITS  to memory i_data
//  i_mem_rdata   in   BITS  from memory o_data
// BEHAVIOUR
//  Reset: all outputs are registered or state-decoded; all return to 0 asynchronously, except o_cmd_ready = 1.
//   o_mem_rw drops in the same instant reset asserts, so a mid-write reset never completes the strobe.
//  o_cmd_ready = (state == IDLE). o_busy = !IDLE. Command fields are captured at acceptance.
//  States: IDLE, RD, RSP, WSETUP, WSTROBE, WHOLD, CRD.
//  READ (accepted at edge T):
//   - RD cycle T+1: addr driven, rw = 0.
//   - Edge T+2: i_mem_rdata is captured; o_rsp_valid = 1 from T+2.
//   - RSP holds data stable until i_rsp_ready. Handshake edge: valid drops, done pulses next cycle, return to IDLE.
//  WRITE:
//   - WSETUP: addr/data driven, rw = 0.
//   - WSTROBE: rw = 1.
//   - WHOLD: rw = 0, addr/data unchanged.
//   - Then IDLE with o_done = 1 for that one cycle. Acceptance to ready = 4 cycles.
//   - addr/wdata never change while rw = 1 or in the adjacent cycles.
//  FILL: WSETUP/WSTROBE/WHOLD per word at addr, addr+1, ... (len words, wrap mod 2**BITS). 3 cycles per word.
//  COPY, per word:
//   - CRD: drive src, rw = 0; capture i_mem_rdata at the end of the cycle.
//   - Then WSETUP/WSTROBE/WHOLD at dst. 4 cycles per word.
//   - Ascending order; src/dst both increment with wrap.
//   - Overlap with dst in (src, src+len) propagates forward; this is defined behaviour, not an error.
//  len = 0 (FILL/COPY): no memory access; IDLE next cycle with o_done pulse.
//  Down-counter of BITS width, so max len is 2**BITS-1.
//  i_cmd_valid while busy is ignored (ready low). i_rsp_ready outside RSP is ignored.
//  o_done never coincides with o_cmd_ready deasserted; it is high only in the first IDLE cycle after completion.
//  Reset mid-command abandons it: no done, no rsp.
// STRUCTURE
//  mem_master_pkg:
//   - op_e {OP_READ, OP_WRITE, OP_FILL, OP_COPY}
//   - state_e (7 states above)
//  Single FSM plus address/count/temp registers. No sub-module; the write strobe sequence is shared by WRITE/FILL/COPY states.
// TESTING
//  1 Reset: hold i_rst_n = 0 -> rw = 0, rsp_valid = 0, ready = 1. Assert reset during WSTROBE -> rw falls without a clock edge; memory word unchanged.
//  2 WRITE addr=0x10 data=0xA5, then READ 0x10 with rsp_ready = 1 -> rsp_valid at T+2 with data 0xA5.
//    Rw high for exactly 1 cycle, with addr/data stable across SETUP..HOLD.
//  3 READ 0x10, rsp_ready held 0 for 5 cycles -> rsp_valid/data stable, ready low throughout.
//    Rsp_ready = 1 -> done pulse next cycle.
//  4 FILL addr=0xFE len=4 val=0x3C -> 0xFE, 0xFF, 0x00, 0x01 = 0x3C; 0x02 untouched; done after 12 cycles.
//  5 COPY src=0x20 dst=0x21 len=3, mem[0x20..0x22] = 1,2,3 -> mem[0x21..0x23] = 1,1,1; 12 cycles.
//  6 FILL len=0 -> no rw pulse, done on next cycle. Cmd_valid while busy -> no extra command.

Source files
------------

// File: rtl/mem_master_pkg.sv
// Shared types for the mem_master memory initiator: command opcodes and FSM states.
package mem_master_pkg;

  localparam int DATA_BITS = 8;
  localparam int MEMADDRS  = 256;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_FILL  = 2'd2,
    OP_COPY  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RSP     = 3'd2,
    WSETUP  = 3'd3,
    WSTROBE = 3'd4,
    WHOLD   = 3'd5,
    CRD     = 3'd6
  } state_e;

endpackage

// File: rtl/mem_master_if.sv
// Command/response port (CPU side) and memory bus port (memory side) for mem_master.
// Handshakes: a transfer happens on a rising edge where valid && ready; the producer
// holds valid and its payload stable until then, and ready may depend on state only.
interface mem_cmd_if #(parameter int BITS = mem_master_pkg::DATA_BITS);
  import mem_master_pkg::*;
  logic            cmd_valid;
  logic            cmd_ready;
  op_e             cmd_op;
  logic [BITS-1:0] cmd_addr;
  logic [BITS-1:0] cmd_aux;
  logic [BITS-1:0] cmd_len;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [BITS-1:0] rsp_data;
  logic            done;
  logic            busy;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_aux, cmd_len, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, done, busy
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_aux, cmd_len, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, done, busy
  );
endinterface

interface mem_bus_if #(parameter int BITS = mem_master_pkg::DATA_BITS);
  logic            rw;
  logic [BITS-1:0] addr;
  logic [BITS-1:0] wdata;
  logic [BITS-1:0] rdata;

  modport master (output rw, addr, wdata, input rdata);
  modport slave  (input rw, addr, wdata, output rdata);
endinterface

// File: rtl/mem_master.sv
// Bus initiator for an async-write / combinational-read memory: READ, WRITE, FILL, COPY.
// One FSM drives a shared SETUP/STROBE/HOLD write sequence for WRITE, FILL and COPY.
module mem_master
  import mem_master_pkg::*;
#(
  parameter int BITS = DATA_BITS
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  mem_cmd_if.slave  cmd,
  mem_bus_if.master mem,
  output state_e dbg_state
);

  state_e          state_q, state_d;
  op_e             op_q;
  logic            done_q, done_d;
  logic [BITS-1:0] addr_q, wdata_q, rsp_data_q;
  logic [BITS-1:0] src_q, dst_q, count_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd.cmd_valid) begin
          case (cmd.cmd_op)
            OP_READ:  state_d = RD;
            OP_WRITE: state_d = WSETUP;
            OP_FILL: begin
              if (cmd.cmd_len == '0) done_d  = 1'b1;
              else                   state_d = WSETUP;
            end
            default: begin
              if (cmd.cmd_len == '0) done_d  = 1'b1;
              else                   state_d = CRD;
            end
          endcase
        end
      end
      RD:      state_d = RSP;
      RSP: begin
        if (cmd.rsp_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      WSETUP:  state_d = WSTROBE;
      WSTROBE: state_d = WHOLD;
      WHOLD: begin
        // count_q is meaningless for WRITE, so test the opcode first
        if (op_q == OP_WRITE || count_q == BITS'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (op_q == OP_COPY) begin
          state_d = CRD;
        end else begin
          state_d = WSETUP;
        end
      end
      CRD:     state_d = WSETUP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q       <= OP_READ;
      done_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      count_q    <= '0;
    end else begin
      done_q <= done_d;
      case (state_q)
        IDLE: begin
          if (cmd.cmd_valid) begin
            op_q    <= cmd.cmd_op;
            addr_q  <= cmd.cmd_addr;
            wdata_q <= cmd.cmd_aux;
            count_q <= cmd.cmd_len;
            src_q   <= cmd.cmd_addr;
            dst_q   <= cmd.cmd_aux;
          end
        end
        RD:  rsp_data_q <= mem.rdata;
        CRD: begin
          wdata_q <= mem.rdata;
          addr_q  <= dst_q;
        end
        WHOLD: begin
          // Address only moves after HOLD, keeping it stable around the strobe
          count_q <= count_q - 1'b1;
          if (op_q == OP_FILL) begin
            addr_q <= addr_q + 1'b1;
          end else if (op_q == OP_COPY) begin
            src_q  <= src_q + 1'b1;
            dst_q  <= dst_q + 1'b1;
            addr_q <= src_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobe is state-decoded so an asynchronous reset drops it immediately
  assign mem.rw        = (state_q == WSTROBE);
  assign mem.addr      = addr_q;
  assign mem.wdata     = wdata_q;
  assign cmd.cmd_ready = (state_q == IDLE);
  assign cmd.busy      = (state_q != IDLE);
  assign cmd.rsp_valid = (state_q == RSP);
  assign cmd.rsp_data  = rsp_data_q;
  assign cmd.done      = done_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master with a behavioural memory that commits a word on a
// rising edge while rw is high and reads combinationally.
module tb_mem_master;
  import mem_master_pkg::*;

  logic   clk;
  logic   rst_n;
  state_e dbg_state;
  int     checks   = 0;
  int     failures = 0;

  mem_cmd_if #(.BITS(8)) cmd ();
  mem_bus_if #(.BITS(8)) bus ();

  mem_master #(.BITS(8)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .cmd       (cmd),
    .mem       (bus),
    .dbg_state (dbg_state)
  );

  // clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem_arr [0:255];
  always @(posedge clk) if (bus.rw) mem_arr[bus.addr] <= bus.wdata;
  assign bus.rdata = mem_arr[bus.addr];

  // driver tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the accepting edge (first cycle of the command).
  task automatic send(input op_e op, input logic [7:0] addr, input logic [7:0] aux,
                      input logic [7:0] len);
    int n;
    cmd.cmd_valid = 1'b1;
    cmd.cmd_op    = op;
    cmd.cmd_addr  = addr;
    cmd.cmd_aux   = aux;
    cmd.cmd_len   = len;
    n = 0;
    while (!cmd.cmd_ready && n < 50) begin
      tick();
      n++;
    end
    check("cmd_accept", {31'd0, cmd.cmd_ready}, 32'd1);
    tick();
    cmd.cmd_valid = 1'b0;
  endtask

  // Cycles counted from the first command cycle (1) to the cycle showing done.
  task automatic run_to_done(output int cycles, output int pulses, output int max_run);
    int run;
    cycles = 1; pulses = 0; max_run = 0; run = 0;
    while (!cmd.done && cycles < 200) begin
      if (bus.rw) begin
        pulses++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      tick();
      cycles++;
    end
  endtask

  task automatic write_word(input logic [7:0] a, input logic [7:0] d);
    int c, p, m;
    send(OP_WRITE, a, d, 8'd0);
    run_to_done(c, p, m);
  endtask

  int         cyc, pul, mrun;
  logic [7:0] saved;

  initial begin
    rst_n         = 1'b0;
    cmd.cmd_valid = 1'b0;
    cmd.cmd_op    = OP_READ;
    cmd.cmd_addr  = '0;
    cmd.cmd_aux   = '0;
    cmd.cmd_len   = '0;
    cmd.rsp_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem_arr[i] = 8'h00;

    // reset state
    #1;
    check("rst_rw",        {31'd0, bus.rw}, 32'd0);
    check("rst_rsp_valid", {31'd0, cmd.rsp_valid}, 32'd0);
    check("rst_ready",     {31'd0, cmd.cmd_ready}, 32'd1);
    check("rst_busy",      {31'd0, cmd.busy}, 32'd0);
    check("rst_done",      {31'd0, cmd.done}, 32'd0);
    check("rst_state",     {29'd0, dbg_state}, {29'd0, IDLE});
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // WRITE 0x10 = 0xA5, cycle by cycle
    send(OP_WRITE, 8'h10, 8'hA5, 8'd0);
    check("wr_setup_rw",    {31'd0, bus.rw}, 32'd0);
    check("wr_setup_addr",  {24'd0, bus.addr}, 32'h10);
    check("wr_setup_data",  {24'd0, bus.wdata}, 32'hA5);
    check("wr_setup_ready", {31'd0, cmd.cmd_ready}, 32'd0);
    check("wr_setup_busy",  {31'd0, cmd.busy}, 32'd1);
    tick();
    check("wr_strobe_rw",   {31'd0, bus.rw}, 32'd1);
    check("wr_strobe_addr", {24'd0, bus.addr}, 32'h10);
    check("wr_strobe_data", {24'd0, bus.wdata}, 32'hA5);
    tick();
    check("wr_hold_rw",     {31'd0, bus.rw}, 32'd0);
    check("wr_hold_addr",   {24'd0, bus.addr}, 32'h10);
    check("wr_hold_data",   {24'd0, bus.wdata}, 32'hA5);
    check("wr_hold_done",   {31'd0, cmd.done}, 32'd0);
    tick();
    check("wr_end_ready",   {31'd0, cmd.cmd_ready}, 32'd1);
    check("wr_end_done",    {31'd0, cmd.done}, 32'd1);
    check("wr_mem",         {24'd0, mem_arr[8'h10]}, 32'hA5);
    tick();
    check("wr_done_pulse",  {31'd0, cmd.done}, 32'd0);

    // READ 0x10 with rsp_ready high
    cmd.rsp_ready = 1'b1;
    send(OP_READ, 8'h10, 8'h00, 8'd0);
    check("rd_addr",        {24'd0, bus.addr}, 32'h10);
    check("rd_rw",          {31'd0, bus.rw}, 32'd0);
    check("rd_t1_valid",    {31'd0, cmd.rsp_valid}, 32'd0);
    tick();
    check("rd_t2_valid",    {31'd0, cmd.rsp_valid}, 32'd1);
    check("rd_t2_data",     {24'd0, cmd.rsp_data}, 32'hA5);
    tick();
    check("rd_t3_valid",    {31'd0, cmd.rsp_valid}, 32'd0);
    check("rd_t3_done",     {31'd0, cmd.done}, 32'd1);
    check("rd_t3_ready",    {31'd0, cmd.cmd_ready}, 32'd1);
    cmd.rsp_ready = 1'b0;

    // READ 0x10 with back-pressure
    send(OP_READ, 8'h10, 8'h00, 8'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, cmd.rsp_valid}, 32'd1);
      check("bp_data",  {24'd0, cmd.rsp_data}, 32'hA5);
      check("bp_ready", {31'd0, cmd.cmd_ready}, 32'd0);
      check("bp_done",  {31'd0, cmd.done}, 32'd0);
      tick();
    end
    cmd.rsp_ready = 1'b1;
    tick();
    cmd.rsp_ready = 1'b0;
    check("bp_end_valid", {31'd0, cmd.rsp_valid}, 32'd0);
    check("bp_end_done",  {31'd0, cmd.done}, 32'd1);
    tick();
    check("bp_done_pulse", {31'd0, cmd.done}, 32'd0);

    // FILL 0xFE len 4 across the address wrap
    write_word(8'h02, 8'h77);
    tick();
    send(OP_FILL, 8'hFE, 8'h3C, 8'd4);
    run_to_done(cyc, pul, mrun);
    check("fill_cycles", cyc, 32'd13);
    check("fill_pulses", pul, 32'd4);
    check("fill_strobe_len", mrun, 32'd1);
    check("fill_fe", {24'd0, mem_arr[8'hFE]}, 32'h3C);
    check("fill_ff", {24'd0, mem_arr[8'hFF]}, 32'h3C);
    check("fill_00", {24'd0, mem_arr[8'h00]}, 32'h3C);
    check("fill_01", {24'd0, mem_arr[8'h01]}, 32'h3C);
    check("fill_02_untouched", {24'd0, mem_arr[8'h02]}, 32'h77);

    // COPY with forward overlap: 1,2,3 at 0x20 -> 0x21..0x23 all become 1
    write_word(8'h20, 8'h01);
    write_word(8'h21, 8'h02);
    write_word(8'h22, 8'h03);
    write_word(8'h23, 8'h55);
    tick();
    send(OP_COPY, 8'h20, 8'h21, 8'd3);
    run_to_done(cyc, pul, mrun);
    check("copy_cycles", cyc, 32'd13);
    check("copy_pulses", pul, 32'd3);
    check("copy_20", {24'd0, mem_arr[8'h20]}, 32'h01);
    check("copy_21", {24'd0, mem_arr[8'h21]}, 32'h01);
    check("copy_22", {24'd0, mem_arr[8'h22]}, 32'h01);
    check("copy_23", {24'd0, mem_arr[8'h23]}, 32'h01);
    check("copy_24", {24'd0, mem_arr[8'h24]}, 32'h00);

    // FILL len 0: done on the next cycle, no strobe
    tick();
    saved = mem_arr[8'h40];
    send(OP_FILL, 8'h40, 8'h99, 8'd0);
    run_to_done(cyc, pul, mrun);
    check("fill0_cycles", cyc, 32'd1);
    check("fill0_pulses", pul, 32'd0);
    check("fill0_mem", {24'd0, mem_arr[8'h40]}, {24'd0, saved});

    // Command offered while busy must not be taken
    tick();
    saved = mem_arr[8'h60];
    send(OP_FILL, 8'h50, 8'h11, 8'd2);
    cmd.cmd_valid = 1'b1;
    cmd.cmd_op    = OP_WRITE;
    cmd.cmd_addr  = 8'h60;
    cmd.cmd_aux   = 8'hEE;
    run_to_done(cyc, pul, mrun);
    cmd.cmd_valid = 1'b0;
    check("busy_cycles", cyc, 32'd7);
    check("busy_pulses", pul, 32'd2);
    check("busy_50", {24'd0, mem_arr[8'h50]}, 32'h11);
    check("busy_51", {24'd0, mem_arr[8'h51]}, 32'h11);
    tick();
    check("busy_ignored_state", {29'd0, dbg_state}, {29'd0, IDLE});
    check("busy_ignored_mem", {24'd0, mem_arr[8'h60]}, {24'd0, saved});

    // Reset asserted during WSTROBE drops rw without a clock edge
    write_word(8'h70, 8'h12);
    tick();
    send(OP_WRITE, 8'h70, 8'h34, 8'd0);
    tick();
    check("rstw_strobe", {31'd0, bus.rw}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstw_rw_async", {31'd0, bus.rw}, 32'd0);
    check("rstw_ready",    {31'd0, cmd.cmd_ready}, 32'd1);
    check("rstw_busy",     {31'd0, cmd.busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rstw_mem",  {24'd0, mem_arr[8'h70]}, 32'h12);
    check("rstw_done", {31'd0, cmd.done}, 32'd0);
    check("rstw_rsp",  {31'd0, cmd.rsp_valid}, 32'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
